cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Single-port memory arbiter directly downstream of the instruction and data caches.
- Accepts concurrent refill/read requests from the icache and read/write-back requests from the dcache.
- Grants one requester at a time to the shared RAM port and returns load data plus wait/acknowledge to the granted cache.
- Sits between the caches' memory-side interface and the RAM model/controller.

Parameters:
- WORD_W, 32, data and address width in bits
- RAMSTATE_W, 2, width of RAM status encoding

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache read address
- iload  out  WORD_W  icache read data
- iwait  out  1  icache wait; low for exactly the completion cycle
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  WORD_W  dcache address
- dstore  in  WORD_W  dcache write data
- dload  out  WORD_W  dcache read data
- dwait  out  1  dcache wait; low for exactly the completion cycle
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  RAMSTATE_W  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset (async, nRST low):
  - state = IDLE.
  - ramREN = 0, ramWEN = 0, ramaddr = 0, ramstore = 0.
  - iwait = 1, dwait = 1, iload = 0, dload = 0.
  - Reset mid-transaction abandons the access immediately; no ack is issued.
- States are IDLE, IGNT, DGNT. State is registered; all outputs are combinational from state and inputs.
- IDLE:
  - No RAM enables asserted. Both waits = 1.
  - If dREN or dWEN: next state is DGNT.
  - Else if iREN: next state is IGNT.
  - Else stay in IDLE.
- DGNT:
  - ramaddr = daddr, ramstore = dstore.
  - ramWEN = dWEN; ramREN = dREN & ~dWEN (write wins when both asserted).
  - iwait = 1.
  - When ramstate == ACCESS: dwait = 0 and dload = ramload that cycle; next state is IDLE.
  - Otherwise dwait = 1 and the state holds.
- IGNT:
  - ramaddr = iaddr, ramREN = 1, ramWEN = 0.
  - dwait = 1.
  - When ramstate == ACCESS: iwait = 0 and iload = ramload; next state is IDLE.
  - Otherwise the state holds.
- iload and dload equal ramload only in their own completion cycle; they are 0 otherwise.
- Latency:
  - Request seen in IDLE at cycle N: RAM enables assert at cycle N+1.
  - Earliest ack is cycle N+1 if the RAM returns ACCESS that cycle.
  - Every transaction is followed by one mandatory IDLE cycle, which forces re-arbitration.
- ramstate BUSY or FREE while granted: keep driving the enables, hold the state, and hold wait = 1.
- ramstate ERROR while granted: same as BUSY (retry indefinitely). No ack is ever given on ERROR.
- Requester deasserts its request while granted (no ACCESS yet):
  - Drop all RAM enables that same cycle.
  - Return to IDLE next cycle; no ack.
- Simultaneous requests in IDLE: data side wins (strict priority) unless ARB_FAIR_EN is defined.
- Address/data changes while granted: passed straight through. Caches must hold them stable; the arbiter does not latch them.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - Add a 1-bit register last_d, reset 0, updated on each completion: 1 after a data ack, 0 after an instruction ack.
  - In IDLE with both sides requesting: grant icache if last_d = 1, else grant dcache.
  - A single requester is always granted.
- Undefined:
  - Strict data-over-instruction priority; no last_d register.
  - An icache request can starve while dcache requests keep arriving.

Test Plan:
- Reset: hold nRST low with iREN = 1, dREN = 1 → ramREN = 0, ramWEN = 0, iwait = 1, dwait = 1, iload = 0, dload = 0.
- Lone icache read, iaddr = 0x40, RAM returns ACCESS on its 2nd granted cycle with ramload = 0xDEADBEEF:
  - ramaddr = 0x40, ramREN = 1 for 2 cycles.
  - iwait = 0 with iload = 0xDEADBEEF for exactly 1 cycle, then IDLE for 1 cycle.
- Simultaneous iREN (iaddr 0x10) and dWEN (daddr 0x80, dstore 0x1234):
  - Write is served first: ramWEN = 1, ramaddr = 0x80, ramstore = 0x1234, dwait pulses low.
  - After the IDLE cycle the icache is granted and served.
- dREN and dWEN both high → ramWEN = 1, ramREN = 0.
- ramstate = ERROR for 3 cycles, then ACCESS, on a dcache read → dwait stays 1 through the ERROR cycles; ack on the ACCESS cycle.
- Abort: iREN drops on the 2nd IGNT cycle with ramstate = BUSY → ramREN drops the same cycle, no iwait pulse, IDLE next cycle.
- ARB_FAIR_EN defined, both sides requesting continuously → grants alternate D, I, D, I.
- ARB_FAIR_EN undefined, same stimulus → D every time; iwait never low.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter shared by the icache and dcache memory-side interfaces.
// Optional round-robin between the two caches is enabled by defining ARB_FAIR_EN.
module cache_mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int RAMSTATE_W = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    // icache side
    input  logic                  iREN,
    input  logic [WORD_W-1:0]     iaddr,
    output logic [WORD_W-1:0]     iload,
    output logic                  iwait,
    // dcache side
    input  logic                  dREN,
    input  logic                  dWEN,
    input  logic [WORD_W-1:0]     daddr,
    input  logic [WORD_W-1:0]     dstore,
    output logic [WORD_W-1:0]     dload,
    output logic                  dwait,
    // RAM side
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [WORD_W-1:0]     ramaddr,
    output logic [WORD_W-1:0]     ramstore,
    input  logic [WORD_W-1:0]     ramload,
    input  logic [RAMSTATE_W-1:0] ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [RAMSTATE_W-1:0] RAM_ACCESS = RAMSTATE_W'(2);

    state_t state;
    state_t next_state;

    logic d_req;
    logic ram_ready;

    assign d_req     = dREN | dWEN;
    assign ram_ready = (ramstate == RAM_ACCESS);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

`ifdef ARB_FAIR_EN
    logic last_d;

    // Remembers which side completed most recently; a completion is a wait-low cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (!dwait) begin
            last_d <= 1'b1;
        end else if (!iwait) begin
            last_d <= 1'b0;
        end
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;

        case (state)
            IDLE: begin
`ifdef ARB_FAIR_EN
                if (d_req && iREN) begin
                    next_state = last_d ? IGNT : DGNT;
                end else if (d_req) begin
                    next_state = DGNT;
                end else if (iREN) begin
                    next_state = IGNT;
                end
`else
                if (d_req) begin
                    next_state = DGNT;
                end else if (iREN) begin
                    next_state = IGNT;
                end
`endif
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    // Request withdrawn before completion: release the RAM, no ack.
                    next_state = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (ram_ready) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                    end
                end
            end

            IGNT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ram_ready) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter; expected acks are queued as stimulus is driven
// and checked by a monitor whenever iwait or dwait goes low. Honours ARB_FAIR_EN.
module tb_cache_mem_arbiter;

    localparam logic [1:0]  FREE   = 2'd0;
    localparam logic [1:0]  BUSY   = 2'd1;
    localparam logic [1:0]  ACCESS = 2'd2;
    localparam logic [1:0]  ERROR  = 2'd3;
    localparam logic [31:0] RAM_K  = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload;
    logic        iwait, dwait;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    logic        ram_auto;
    logic [31:0] ramload_drv;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   i_acks  = 0;
    int   d_acks  = 0;

    // Small RAM model: in auto mode the read data is derived from the address.
    assign ramload = ram_auto ? (ramaddr ^ RAM_K) : ramload_drv;

    always #5 CLK = ~CLK;

    cache_mem_arbiter #(.WORD_W(32), .RAMSTATE_W(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_compare(input logic is_d, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_ack", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("ack_side", {31'b0, is_d}, {31'b0, e.is_d});
            check("ack_data", data, e.data);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Ack monitor: sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (!iwait || !dwait) begin
                check("ack_exclusive", {31'b0, iwait ^ dwait}, 32'd1);
            end
            if (!dwait) begin
                d_acks++;
                sb_compare(1'b1, dload);
            end else begin
                check("dload_zero", dload, 32'd0);
            end
            if (!iwait) begin
                i_acks++;
                sb_compare(1'b0, iload);
            end else begin
                check("iload_zero", iload, 32'd0);
            end
        end
    end

    initial begin : main
        int i0, d0;

        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_auto = 1'b0; ramload_drv = '0; ramstate = FREE;

        // Reset with both requests asserted and the RAM claiming ACCESS
        iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS; ramload_drv = 32'hFFFF_FFFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ramREN",   {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN",   {31'b0, ramWEN}, 32'd0);
        check("rst_iwait",    {31'b0, iwait},  32'd1);
        check("rst_dwait",    {31'b0, dwait},  32'd1);
        check("rst_iload",    iload,    32'd0);
        check("rst_dload",    dload,    32'd0);
        check("rst_ramaddr",  ramaddr,  32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE; ramload_drv = '0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        step();

        // Lone icache read, ACCESS on the second granted cycle
        i0 = i_acks;
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK);
        check("i_idle_ramREN", {31'b0, ramREN}, 32'd0);
        step(); ramstate = BUSY;
        @(negedge CLK);
        check("i_g1_ramREN",  {31'b0, ramREN}, 32'd1);
        check("i_g1_ramaddr", ramaddr, 32'h40);
        check("i_g1_iwait",   {31'b0, iwait}, 32'd1);
        step(); push_exp(1'b0, 32'hDEAD_BEEF); ramstate = ACCESS; ramload_drv = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("i_g2_ramREN",  {31'b0, ramREN}, 32'd1);
        check("i_g2_ramaddr", ramaddr, 32'h40);
        step(); iREN = 1'b0; ramstate = FREE; ramload_drv = '0;
        @(negedge CLK);
        check("i_post_ramREN", {31'b0, ramREN}, 32'd0);
        check("i_post_iwait",  {31'b0, iwait}, 32'd1);
        check("i_ack_count",   32'(i_acks - i0), 32'd1);
        step();

        // Simultaneous icache read and dcache write: write first, then the read
        iREN = 1'b1; iaddr = 32'h10;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        step(); push_exp(1'b1, 32'h0BAD_F00D); ramstate = ACCESS; ramload_drv = 32'h0BAD_F00D;
        @(negedge CLK);
        check("s_d_ramWEN",   {31'b0, ramWEN}, 32'd1);
        check("s_d_ramREN",   {31'b0, ramREN}, 32'd0);
        check("s_d_ramaddr",  ramaddr,  32'h80);
        check("s_d_ramstore", ramstore, 32'h1234);
        check("s_d_iwait",    {31'b0, iwait}, 32'd1);
        step(); dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        check("s_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("s_idle_ramREN", {31'b0, ramREN}, 32'd0);
        step(); push_exp(1'b0, 32'h1111_2222); ramstate = ACCESS; ramload_drv = 32'h1111_2222;
        @(negedge CLK);
        check("s_i_ramaddr", ramaddr, 32'h10);
        check("s_i_ramREN",  {31'b0, ramREN}, 32'd1);
        check("s_i_dwait",   {31'b0, dwait}, 32'd1);
        step(); iREN = 1'b0; ramstate = FREE; ramload_drv = '0;
        step();

        // Both sides requesting continuously, RAM always ready
        i0 = i_acks; d0 = d_acks;
        ram_auto = 1'b1; ramstate = ACCESS;
        daddr = 32'h200; iaddr = 32'h300; dREN = 1'b1; iREN = 1'b1;
`ifdef ARB_FAIR_EN
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_exp(1'b1, 32'h200 ^ RAM_K);
            else            push_exp(1'b0, 32'h300 ^ RAM_K);
        end
`else
        for (int k = 0; k < 4; k++) push_exp(1'b1, 32'h200 ^ RAM_K);
`endif
        repeat (8) step();
        dREN = 1'b0; iREN = 1'b0; ram_auto = 1'b0; ramstate = FREE;
        @(negedge CLK);
`ifdef ARB_FAIR_EN
        check("f_i_acks", 32'(i_acks - i0), 32'd2);
        check("f_d_acks", 32'(d_acks - d0), 32'd2);
`else
        check("f_i_acks", 32'(i_acks - i0), 32'd0);
        check("f_d_acks", 32'(d_acks - d0), 32'd4);
`endif
        step();

        // dREN and dWEN together: the write wins
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h55;
        step(); ramstate = BUSY;
        @(negedge CLK);
        check("rw_ramWEN", {31'b0, ramWEN}, 32'd1);
        check("rw_ramREN", {31'b0, ramREN}, 32'd0);
        check("rw_dwait",  {31'b0, dwait},  32'd1);
        step(); push_exp(1'b1, 32'h0000_CAFE); ramstate = ACCESS; ramload_drv = 32'h0000_CAFE;
        step(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; ramload_drv = '0;
        step();

        // dcache read through three ERROR cycles, then ACCESS
        d0 = d_acks;
        dREN = 1'b1; daddr = 32'h60;
        for (int k = 0; k < 3; k++) begin
            step(); ramstate = ERROR; ramload_drv = 32'hEEEE_0000 + 32'(k);
            @(negedge CLK);
            check("err_dwait",  {31'b0, dwait},  32'd1);
            check("err_ramREN", {31'b0, ramREN}, 32'd1);
        end
        step(); push_exp(1'b1, 32'h0000_600D); ramstate = ACCESS; ramload_drv = 32'h0000_600D;
        @(negedge CLK);
        check("err_ack_dwait", {31'b0, dwait}, 32'd0);
        step(); dREN = 1'b0; ramstate = FREE; ramload_drv = '0;
        check("err_ack_count", 32'(d_acks - d0), 32'd1);
        step();

        // icache abort on the second granted cycle while BUSY
        i0 = i_acks;
        iREN = 1'b1; iaddr = 32'h70;
        step(); ramstate = BUSY;
        @(negedge CLK);
        check("ab_g1_ramREN", {31'b0, ramREN}, 32'd1);
        step(); iREN = 1'b0;
        @(negedge CLK);
        check("ab_drop_ramREN", {31'b0, ramREN}, 32'd0);
        check("ab_drop_iwait",  {31'b0, iwait},  32'd1);
        step(); dREN = 1'b1; daddr = 32'h94;
        @(negedge CLK);
        check("ab_idle_ramREN", {31'b0, ramREN}, 32'd0);
        step(); push_exp(1'b1, 32'h0000_0094); ramstate = ACCESS; ramload_drv = 32'h0000_0094;
        @(negedge CLK);
        check("ab_next_ramaddr", ramaddr, 32'h94);
        check("ab_no_iack",      32'(i_acks - i0), 32'd0);
        step(); dREN = 1'b0; ramstate = FREE; ramload_drv = '0;
        step();

        // Reset in the middle of a granted dcache read: no ack
        d0 = d_acks;
        dREN = 1'b1; daddr = 32'h90;
        step(); ramstate = BUSY;
        @(negedge CLK);
        check("mr_ramREN", {31'b0, ramREN}, 32'd1);
        step(); nRST = 1'b0; ramstate = ACCESS; ramload_drv = 32'h1357_9BDF;
        #1;
        check("mr_rst_dwait",  {31'b0, dwait},  32'd1);
        check("mr_rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("mr_rst_dload",  dload, 32'd0);
        dREN = 1'b0; ramstate = FREE; ramload_drv = '0;
        step(); nRST = 1'b1;
        step();
        @(negedge CLK);
        check("mr_post_ramREN", {31'b0, ramREN}, 32'd0);
        check("mr_no_ack",      32'(d_acks - d0), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
